// File: rtl/tile_write_arbiter_if.sv
// Software write channel into the tile-map write arbiter.
// The master drives tile index/id requests and the slave returns ready.
interface tile_write_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 12
) ();
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/tile_write_arbiter.sv
// Queues software tile writes and commits them to the single-port tile-map RAM only during blanking.
// Optional status outputs (drop_count, hwm) are enabled by defining TILE_ARB_STATUS_EN.
module tile_write_arbiter #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 13,
  parameter int DATA_W = 12,
  parameter int TILES  = 4800,
  parameter int GUARD  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  tile_write_arbiter_if.slave    wr,
  input  logic                   blank,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic [DATA_W-1:0]      ram_wdata,
  output logic                   ram_we,
  output logic                   pending,
  output logic [$clog2(DEPTH):0] level
`ifdef TILE_ARB_STATUS_EN
  ,
  output logic [7:0]             drop_count,
  output logic [$clog2(DEPTH):0] hwm
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_VIDEO = 2'd0,
    ST_GUARD = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            state_r, state_nxt;
  logic [3:0]        gcnt_r, gcnt_nxt;
  logic              blank_q_r;
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]  count_r, count_nxt;
  logic [ADDR_W-1:0] mem_addr_r [DEPTH];
  logic [DATA_W-1:0] mem_data_r [DEPTH];

  logic full_s, empty_s, addr_ok_s, push_s, store_s, pop_s, we_s;

  assign full_s    = (count_r == CNT_W'(DEPTH));
  assign empty_s   = (count_r == {CNT_W{1'b0}});
  assign addr_ok_s = ({1'b0, wr.wr_addr} < (ADDR_W+1)'(TILES));
  assign push_s    = wr.wr_valid && !full_s;
  // Out-of-range writes are handshaken but never stored.
  assign store_s   = push_s && addr_ok_s;
  // Gating by live blank makes the strobe drop in the very cycle blank falls.
  assign we_s      = (state_r == ST_DRAIN) && !empty_s && blank;
  assign pop_s     = we_s;

  assign wr.wr_ready = !full_s;
  assign ram_we      = we_s;
  assign ram_addr    = we_s ? mem_addr_r[rd_ptr_r] : rd_addr;
  assign ram_wdata   = mem_data_r[rd_ptr_r];
  assign pending     = !empty_s;
  assign level       = count_r;

  // Next-state logic for the video / guard / drain sequencer.
  always_comb begin
    state_nxt = state_r;
    gcnt_nxt  = gcnt_r;
    case (state_r)
      ST_VIDEO: begin
        if (blank && !blank_q_r) begin
          if (GUARD == 0) begin
            state_nxt = ST_DRAIN;
          end else begin
            state_nxt = ST_GUARD;
            gcnt_nxt  = 4'(GUARD - 1);
          end
        end else begin
          state_nxt = ST_VIDEO;
        end
      end
      ST_GUARD: begin
        if (!blank) begin
          state_nxt = ST_VIDEO;
        end else if (gcnt_r == 4'd0) begin
          state_nxt = ST_DRAIN;
        end else begin
          gcnt_nxt = gcnt_r - 4'd1;
        end
      end
      ST_DRAIN: begin
        if (!blank) begin
          state_nxt = ST_VIDEO;
        end else begin
          state_nxt = ST_DRAIN;
        end
      end
      default: begin
        state_nxt = ST_VIDEO;
        gcnt_nxt  = 4'd0;
      end
    endcase
  end

  // Occupancy update from the stored-push / pop pair.
  always_comb begin
    count_nxt = count_r;
    case ({store_s, pop_s})
      2'b10:   count_nxt = count_r + CNT_W'(1);
      2'b01:   count_nxt = count_r - CNT_W'(1);
      default: count_nxt = count_r;
    endcase
  end

  // Sequencer, blank edge detector and FIFO control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_VIDEO;
      gcnt_r    <= 4'd0;
      blank_q_r <= 1'b0;
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_nxt;
      gcnt_r    <= gcnt_nxt;
      blank_q_r <= blank;
      count_r   <= count_nxt;
      if (store_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
    end
  end

  // FIFO storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (store_s) begin
      mem_addr_r[wr_ptr_r] <= wr.wr_addr;
      mem_data_r[wr_ptr_r] <= wr.wr_data;
    end
  end

`ifdef TILE_ARB_STATUS_EN
  logic [7:0]       drop_cnt_r;
  logic [CNT_W-1:0] hwm_r;

  // Saturating drop counter and occupancy high-water mark.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_r <= 8'd0;
      hwm_r      <= {CNT_W{1'b0}};
    end else begin
      if (((push_s && !addr_ok_s) || (wr.wr_valid && full_s)) && (drop_cnt_r != 8'd255)) begin
        drop_cnt_r <= drop_cnt_r + 8'd1;
      end
      if (count_nxt > hwm_r) begin
        hwm_r <= count_nxt;
      end
    end
  end

  assign drop_count = drop_cnt_r;
  assign hwm        = hwm_r;
`endif

endmodule

// File: tb/tb_tile_write_arbiter.sv
// Directed self-checking bench for tile_write_arbiter (DEPTH=8, GUARD=2, TILES=4800).
module tb_tile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        blank;
  logic [12:0] rd_addr;
  logic [12:0] ram_addr;
  logic [11:0] ram_wdata;
  logic        ram_we;
  logic        pending;
  logic [3:0]  level;
`ifdef TILE_ARB_STATUS_EN
  logic [7:0]  drop_count;
  logic [3:0]  hwm;
`endif

  int checks = 0;
  int errors = 0;

  tile_write_arbiter_if #(.ADDR_W(13), .DATA_W(12)) wr_bus ();

  tile_write_arbiter #(
    .DEPTH(8), .ADDR_W(13), .DATA_W(12), .TILES(4800), .GUARD(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr        (wr_bus.slave),
    .blank     (blank),
    .rd_addr   (rd_addr),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .pending   (pending),
    .level     (level)
`ifdef TILE_ARB_STATUS_EN
    ,
    .drop_count(drop_count),
    .hwm       (hwm)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [12:0] a, input logic [11:0] d);
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_addr  = a;
    wr_bus.wr_data  = d;
    tick();
    wr_bus.wr_valid = 1'b0;
  endtask

  task automatic chk_write(input string tag, input logic [12:0] a, input logic [11:0] d, input logic [3:0] lvl);
    chk({tag, "_we"}, ram_we, 1);
    chk({tag, "_addr"}, ram_addr, a);
    chk({tag, "_data"}, ram_wdata, d);
    chk({tag, "_level"}, level, lvl);
  endtask

  initial begin
    reset = 1'b1;
    blank = 1'b0;
    rd_addr = 13'd77;
    wr_bus.wr_valid = 1'b0;
    wr_bus.wr_addr = 13'd0;
    wr_bus.wr_data = 12'd0;
    tick();
    tick();
    chk("rst_ready", wr_bus.wr_ready, 1);
    chk("rst_we", ram_we, 0);
    chk("rst_pending", pending, 0);
    chk("rst_level", level, 0);
    chk("rst_raddr", ram_addr, 77);
    reset = 1'b0;

    // Three pushes during active video: queued, no RAM write, reader keeps the port.
    rd_addr = 13'd500;
    push(13'd1226, 12'h012);
    chk("q1_level", level, 1);
    chk("q1_raddr", ram_addr, 500);
    rd_addr = 13'd501;
    push(13'd1227, 12'h002);
    push(13'd1228, 12'h00E);
    chk("q3_level", level, 3);
    chk("q3_pending", pending, 1);
    chk("q3_we", ram_we, 0);
    chk("q3_raddr", ram_addr, 501);
    tick();
    chk("q3_we_idle", ram_we, 0);

    // Blank rises: two guard cycles, then three back-to-back writes in order.
    blank = 1'b1;
    tick();
    chk("g0_we", ram_we, 0);
    tick();
    chk("g1_we", ram_we, 0);
    tick();
    chk_write("d0", 13'd1226, 12'h012, 4'd3);
    tick();
    chk_write("d1", 13'd1227, 12'h002, 4'd2);
    tick();
    chk_write("d2", 13'd1228, 12'h00E, 4'd1);
    tick();
    chk("d3_we", ram_we, 0);
    chk("d3_level", level, 0);
    chk("d3_pending", pending, 0);
    chk("d3_raddr", ram_addr, 501);
    blank = 1'b0;
    tick();

    // Out-of-range tile index: handshaken, but nothing is stored.
    chk("bad_ready", wr_bus.wr_ready, 1);
    push(13'd4800, 12'h005);
    chk("bad_level", level, 0);
    chk("bad_pending", pending, 0);
    chk("bad_we", ram_we, 0);
`ifdef TILE_ARB_STATUS_EN
    chk("bad_drops", drop_count, 1);
    chk("bad_hwm", hwm, 3);
`endif

    // Fill to DEPTH; a ninth request is held off until a pop frees a slot.
    for (int i = 0; i < 8; i++) begin
      push(13'(100 + i), 12'(i));
    end
    chk("full_level", level, 8);
    chk("full_ready", wr_bus.wr_ready, 0);
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_addr  = 13'd200;
    wr_bus.wr_data  = 12'd9;
    tick();
    chk("full_hold_level", level, 8);
    chk("full_hold_ready", wr_bus.wr_ready, 0);
    blank = 1'b1;
    tick();
    tick();
    chk("full_guard_level", level, 8);
    tick();
    chk_write("f0", 13'd100, 12'd0, 4'd8);
    chk("f0_ready", wr_bus.wr_ready, 0);
    tick();
    chk_write("f1", 13'd101, 12'd1, 4'd7);
    chk("f1_ready", wr_bus.wr_ready, 1);
    tick();
    chk_write("f2", 13'd102, 12'd2, 4'd7);
    wr_bus.wr_valid = 1'b0;
    for (int i = 3; i < 8; i++) begin
      tick();
      chk_write("fn", 13'(100 + i), 12'(i), 4'(9 - i));
    end
    tick();
    chk_write("f9", 13'd200, 12'd9, 4'd1);
    tick();
    chk("fe_we", ram_we, 0);
    chk("fe_level", level, 0);
`ifdef TILE_ARB_STATUS_EN
    chk("full_hwm", hwm, 8);
`endif
    blank = 1'b0;
    tick();

    // Blank falls after two of five writes; the rest finish in the next blank.
    for (int i = 0; i < 5; i++) begin
      push(13'(300 + i), 12'(48 + i));
    end
    blank = 1'b1;
    tick();
    tick();
    tick();
    chk_write("p0", 13'd300, 12'd48, 4'd5);
    tick();
    chk_write("p1", 13'd301, 12'd49, 4'd4);
    tick();
    chk("p2_we_pre", ram_we, 1);
    blank = 1'b0;
    #1;
    chk("p2_we_cut", ram_we, 0);
    chk("p2_level", level, 3);
    chk("p2_raddr", ram_addr, 501);
    tick();
    tick();
    chk("pv_we", ram_we, 0);
    chk("pv_level", level, 3);
    blank = 1'b1;
    tick();
    tick();
    tick();
    chk_write("r2", 13'd302, 12'd50, 4'd3);
    tick();
    chk_write("r3", 13'd303, 12'd51, 4'd2);
    tick();
    chk_write("r4", 13'd304, 12'd52, 4'd1);
    tick();
    chk("r5_we", ram_we, 0);
    chk("r5_level", level, 0);
    blank = 1'b0;
    tick();

    // Reset in the middle of a drain with four entries still queued.
    push(13'd4799, 12'd7);
    for (int i = 0; i < 5; i++) begin
      push(13'(10 + i), 12'(i));
    end
    blank = 1'b1;
    tick();
    tick();
    tick();
    chk_write("m0", 13'd4799, 12'd7, 4'd6);
    tick();
    chk_write("m1", 13'd10, 12'd0, 4'd5);
    tick();
    chk_write("m2", 13'd11, 12'd1, 4'd4);
    reset = 1'b1;
    #1;
    chk("mr_we", ram_we, 0);
    chk("mr_level", level, 0);
    chk("mr_ready", wr_bus.wr_ready, 1);
    chk("mr_pending", pending, 0);
    chk("mr_raddr", ram_addr, 501);
`ifdef TILE_ARB_STATUS_EN
    chk("mr_drops", drop_count, 0);
    chk("mr_hwm", hwm, 0);
`endif
    tick();
    reset = 1'b0;
    blank = 1'b0;
    tick();
    chk("post_level", level, 0);
    chk("post_we", ram_we, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
